fc_layer_q16: RTL and testbench

Parametrised, signed Q16.16 fully-connected (dense) layer for the inference datapath. Streams one input activation per cycle, multiplies it against every output row in parallel, and adds it into per-output accumulators. Once the input vector is complete, it adds the per-output bias, saturates, optionally applies ReLU, and streams the outputs downstream over a valid/ready handshake. Weights and biases are loaded through a dedicated write port. Adds signed arithmetic, bias, saturation, selectable ReLU, reset and sequence-error detection to the earlier unsigned forward FC.

---
 rtl/fc_layer_q16.sv | 143 ++++++++++++++
 tb/tb_fc_layer_q16.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_q16.sv
// Signed Q16.16 dense layer: streams activations into OUT_DIM parallel accumulators,
// then drains bias-added, saturated (optionally ReLU'd) results over valid/ready.
module fc_layer_q16 #(
    parameter int IN_DIM    = 1024,
    parameter int OUT_DIM   = 10,
    parameter int IDX_WIDTH = 10,
    parameter int ACC_WIDTH = 48,
    parameter bit RELU_EN   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_weights,
    input  logic                 load_bias,
    input  logic                 wt_valid,
    input  logic [IDX_WIDTH-1:0] wt_row,
    input  logic [IDX_WIDTH-1:0] wt_col,
    input  logic [31:0]          wt_data,
    input  logic                 in_valid,
    output logic                 in_rdy,
    input  logic [IDX_WIDTH-1:0] in_idx,
    input  logic [31:0]          in_data,
    output logic                 out_valid,
    input  logic                 out_rdy,
    output logic [IDX_WIDTH-1:0] out_idx,
    output logic [31:0]          out_data,
    output logic                 out_last,
    output logic                 seq_err,
    input  logic                 clr_err
);

    localparam int COL_AW = (IN_DIM  > 1) ? $clog2(IN_DIM)  : 1;
    localparam int ROW_AW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IN  = IDX_WIDTH'(IN_DIM - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_OUT = IDX_WIDTH'(OUT_DIM - 1);
    localparam logic [IDX_WIDTH:0]   ROW_LIM  = (IDX_WIDTH + 1)'(OUT_DIM);
    localparam logic [IDX_WIDTH:0]   COL_LIM  = (IDX_WIDTH + 1)'(IN_DIM);

    typedef enum logic {ST_ACCUM, ST_DRAIN} state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [IDX_WIDTH-1:0]         r_count;
    logic [IDX_WIDTH-1:0]         r_out_idx;
    logic                         r_seq_err;
    logic signed [ACC_WIDTH-1:0]  r_acc    [OUT_DIM];
    logic signed [31:0]           r_weight [OUT_DIM][IN_DIM];
    logic signed [31:0]           r_bias   [OUT_DIM];

    logic signed [63:0]           w_prod   [OUT_DIM];
    logic signed [ACC_WIDTH-1:0]  w_inc    [OUT_DIM];
    logic [COL_AW-1:0]            w_col;
    logic [ROW_AW-1:0]            w_sel;
    logic                         w_accept;
    logic                         w_in_ok;
    logic                         w_in_bad;
    logic                         w_out_fire;
    logic                         w_drain_done;
    logic                         w_row_ok;
    logic                         w_col_ok;
    logic                         w_wr_w;
    logic                         w_wr_b;
    logic signed [ACC_WIDTH-1:0]  w_sum;
    logic [ACC_WIDTH-32:0]        w_hi;
    logic [31:0]                  w_sat;
    logic [31:0]                  w_res;

    assign in_rdy       = (r_state == ST_ACCUM) & ~(load_weights | load_bias);
    assign w_accept     = in_valid & in_rdy;
    assign w_in_ok      = w_accept & (in_idx == r_count);
    assign w_in_bad     = w_accept & (in_idx != r_count);
    assign w_out_fire   = (r_state == ST_DRAIN) & out_rdy;
    assign w_drain_done = w_out_fire & (r_out_idx == LAST_OUT);
    assign w_col        = in_idx[COL_AW-1:0];
    assign w_sel        = r_out_idx[ROW_AW-1:0];

    assign w_row_ok = {1'b0, wt_row} < ROW_LIM;
    assign w_col_ok = {1'b0, wt_col} < COL_LIM;
    assign w_wr_w   = wt_valid & load_weights & w_row_ok & w_col_ok;
    assign w_wr_b   = wt_valid & ~load_weights & load_bias & w_row_ok;

    // Full 64-bit signed product, rescaled to Q16.16 before entering the accumulator.
    always_comb begin
        for (int r = 0; r < OUT_DIM; r++) begin
            w_prod[r] = 64'(r_weight[r][w_col]) * 64'($signed(in_data));
            w_inc[r]  = ACC_WIDTH'(w_prod[r] >>> 16);
        end
    end

    always_comb begin
        w_sum = r_acc[w_sel] + ACC_WIDTH'(r_bias[w_sel]);
        w_hi  = w_sum[ACC_WIDTH-1:31];
        if ((&w_hi) | ~(|w_hi)) w_sat = w_sum[31:0];
        else if (w_sum[ACC_WIDTH-1]) w_sat = 32'h8000_0000;
        else w_sat = 32'h7FFF_FFFF;
        w_res = w_sat;
        if (RELU_EN && w_sat[31]) w_res = '0;
    end

    assign out_valid = (r_state == ST_DRAIN);
    assign out_idx   = r_out_idx;
    assign out_data  = out_valid ? w_res : '0;
    assign out_last  = out_valid & (r_out_idx == LAST_OUT);
    assign seq_err   = r_seq_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACCUM: if (w_in_ok && (r_count == LAST_IN)) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_drain_done) w_state_nxt = ST_ACCUM;
            default:  w_state_nxt = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_ACCUM;
            r_count   <= '0;
            r_out_idx <= '0;
            r_seq_err <= 1'b0;
            for (int r = 0; r < OUT_DIM; r++) r_acc[r] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_drain_done) r_count <= '0;
            else if (w_in_ok) r_count <= r_count + 1'b1;
            if (w_drain_done) r_out_idx <= '0;
            else if (w_out_fire) r_out_idx <= r_out_idx + 1'b1;
            // A new error wins over a simultaneous clear.
            if (w_in_bad) r_seq_err <= 1'b1;
            else if (clr_err) r_seq_err <= 1'b0;
            for (int r = 0; r < OUT_DIM; r++) begin
                if (w_drain_done) r_acc[r] <= '0;
                else if (w_in_ok) r_acc[r] <= r_acc[r] + w_inc[r];
            end
        end
    end

    // Coefficient storage is deliberately left out of reset so it survives rst_n.
    always_ff @(posedge clk) begin
        if (w_wr_w) r_weight[wt_row[ROW_AW-1:0]][wt_col[COL_AW-1:0]] <= wt_data;
        if (w_wr_b) r_bias[wt_row[ROW_AW-1:0]] <= wt_data;
    end

endmodule

// File: tb/tb_fc_layer_q16.sv
// Directed bench for fc_layer_q16: a ReLU instance and a signed pass-through
// instance share all inputs and are checked against hand-computed Q16.16 results.
module tb_fc_layer_q16;

    localparam int IN_DIM  = 4;
    localparam int OUT_DIM = 2;
    localparam int IDXW    = 2;
    localparam int ACCW    = 48;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            load_weights, load_bias, wt_valid;
    logic [IDXW-1:0] wt_row, wt_col;
    logic [31:0]     wt_data;
    logic            in_valid;
    logic [IDXW-1:0] in_idx;
    logic [31:0]     in_data;
    logic            out_rdy, clr_err;

    logic            r_in_rdy, r_out_valid, r_out_last, r_seq_err;
    logic [IDXW-1:0] r_out_idx;
    logic [31:0]     r_out_data;
    logic            l_in_rdy, l_out_valid, l_out_last, l_seq_err;
    logic [IDXW-1:0] l_out_idx;
    logic [31:0]     l_out_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fc_layer_q16 #(.IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .IDX_WIDTH(IDXW),
                   .ACC_WIDTH(ACCW), .RELU_EN(1'b1)) u_relu (
        .clk(clk), .rst_n(rst_n), .load_weights(load_weights), .load_bias(load_bias),
        .wt_valid(wt_valid), .wt_row(wt_row), .wt_col(wt_col), .wt_data(wt_data),
        .in_valid(in_valid), .in_rdy(r_in_rdy), .in_idx(in_idx), .in_data(in_data),
        .out_valid(r_out_valid), .out_rdy(out_rdy), .out_idx(r_out_idx),
        .out_data(r_out_data), .out_last(r_out_last), .seq_err(r_seq_err),
        .clr_err(clr_err));

    fc_layer_q16 #(.IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .IDX_WIDTH(IDXW),
                   .ACC_WIDTH(ACCW), .RELU_EN(1'b0)) u_lin (
        .clk(clk), .rst_n(rst_n), .load_weights(load_weights), .load_bias(load_bias),
        .wt_valid(wt_valid), .wt_row(wt_row), .wt_col(wt_col), .wt_data(wt_data),
        .in_valid(in_valid), .in_rdy(l_in_rdy), .in_idx(in_idx), .in_data(in_data),
        .out_valid(l_out_valid), .out_rdy(out_rdy), .out_idx(l_out_idx),
        .out_data(l_out_data), .out_last(l_out_last), .seq_err(l_seq_err),
        .clr_err(clr_err));

    task automatic wr_w(input int row, input int col, input logic [31:0] d);
        load_weights = 1'b1; wt_valid = 1'b1;
        wt_row = IDXW'(row); wt_col = IDXW'(col); wt_data = d;
        @(posedge clk); #1;
        wt_valid = 1'b0; load_weights = 1'b0;
    endtask

    task automatic wr_b(input int row, input logic [31:0] d);
        load_bias = 1'b1; wt_valid = 1'b1;
        wt_row = IDXW'(row); wt_col = '0; wt_data = d;
        @(posedge clk); #1;
        wt_valid = 1'b0; load_bias = 1'b0;
    endtask

    task automatic setw(input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] b0, input logic [31:0] b1);
        for (int c = 0; c < IN_DIM; c++) begin
            wr_w(0, c, w0);
            wr_w(1, c, w1);
        end
        wr_b(0, b0);
        wr_b(1, b1);
    endtask

    task automatic send(input int idx, input logic [31:0] d);
        in_valid = 1'b1; in_idx = IDXW'(idx); in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Drains one output vector with out_rdy high; ok reports whether the
    // valid/idx/last/in_rdy sequence had the required shape.
    task automatic collect(output logic [31:0] r0, output logic [31:0] r1,
                           output logic [31:0] l0, output logic [31:0] l1,
                           output logic ok);
        ok = 1'b1;
        out_rdy = 1'b1;
        if (!(r_out_valid && l_out_valid && r_out_idx == 2'd0 && l_out_idx == 2'd0
              && !r_out_last && !l_out_last)) ok = 1'b0;
        r0 = r_out_data; l0 = l_out_data;
        @(posedge clk); #1;
        if (!(r_out_valid && l_out_valid && r_out_idx == 2'd1 && l_out_idx == 2'd1
              && r_out_last && l_out_last)) ok = 1'b0;
        r1 = r_out_data; l1 = l_out_data;
        @(posedge clk); #1;
        if (r_out_valid || l_out_valid || !r_in_rdy || !l_in_rdy) ok = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] got;
        got = {r_in_rdy, l_in_rdy, r_out_valid, l_out_valid, r_out_last, l_out_last,
               r_seq_err, l_seq_err, r_out_idx, l_out_idx};
        checks++;
        if (got !== 12'b110000000000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected %b", got, 12'b110000000000);
        end
        checks++;
        if ({r_out_data, l_out_data} !== 64'h0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", {r_out_data, l_out_data});
        end
    endtask

    task automatic test_identity();
        logic [31:0] r0, r1, l0, l1;
        logic ok;
        setw(32'h0001_0000, 32'hFFFF_0000, 32'h0, 32'h0);
        for (int i = 0; i < IN_DIM; i++) send(i, 32'((i + 1) << 16));
        collect(r0, r1, l0, l1, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL id_handshake: got %b expected 1", ok); end
        checks++;
        if ({r0, l0} !== {32'h000A_0000, 32'h000A_0000}) begin
            errors++; $display("FAIL id_out0: got %h/%h expected 000a0000", r0, l0);
        end
        checks++;
        if (r1 !== 32'h0) begin errors++; $display("FAIL id_relu_out1: got %h expected 0", r1); end
        checks++;
        if (l1 !== 32'hFFF6_0000) begin
            errors++; $display("FAIL id_lin_out1: got %h expected fff60000", l1);
        end
    endtask

    task automatic test_bias();
        logic [31:0] r0, r1, l0, l1;
        logic ok;
        setw(32'h0001_0000, 32'hFFFF_0000, 32'h0, 32'h0000_8000);
        wr_w(2, 0, 32'h0005_0000);
        wr_b(3, 32'h1234_5678);
        for (int i = 0; i < IN_DIM; i++) send(i, 32'((i + 1) << 16));
        collect(r0, r1, l0, l1, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL bias_handshake: got %b expected 1", ok); end
        checks++;
        if (l1 !== 32'hFFF6_8000) begin
            errors++; $display("FAIL bias_lin_out1: got %h expected fff68000", l1);
        end
        checks++;
        if ({r0, r1} !== {32'h000A_0000, 32'h0}) begin
            errors++; $display("FAIL bias_relu: got %h/%h expected 000a0000/0", r0, r1);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] r0, r1, l0, l1;
        logic ok;
        setw(32'h7FFF_0000, 32'h8001_0000, 32'h0, 32'h0);
        send(0, 32'h7FFF_0000);
        for (int i = 1; i < IN_DIM; i++) send(i, 32'h0);
        collect(r0, r1, l0, l1, ok);
        checks++;
        if ({r0, l0} !== {32'h7FFF_FFFF, 32'h7FFF_FFFF}) begin
            errors++; $display("FAIL sat_pos: got %h/%h expected 7fffffff", r0, l0);
        end
        checks++;
        if (l1 !== 32'h8000_0000) begin
            errors++; $display("FAIL sat_neg: got %h expected 80000000", l1);
        end
        checks++;
        if (r1 !== 32'h0) begin errors++; $display("FAIL sat_neg_relu: got %h expected 0", r1); end
    endtask

    task automatic test_seq_err();
        logic [31:0] r0, r1, l0, l1;
        logic ok;
        setw(32'h0001_0000, 32'hFFFF_0000, 32'h0, 32'h0000_8000);
        send(0, 32'h0001_0000);
        send(2, 32'h0003_0000);
        checks++;
        if ({r_seq_err, l_seq_err, r_in_rdy, l_in_rdy} !== 4'b1111) begin
            errors++; $display("FAIL seq_err_set: got %b expected 1111",
                               {r_seq_err, l_seq_err, r_in_rdy, l_in_rdy});
        end
        for (int i = 1; i < IN_DIM; i++) send(i, 32'((i + 1) << 16));
        collect(r0, r1, l0, l1, ok);
        checks++;
        if ({ok, r0, l1} !== {1'b1, 32'h000A_0000, 32'hFFF6_8000}) begin
            errors++; $display("FAIL seq_resend: got %b %h %h expected 1 000a0000 fff68000", ok, r0, l1);
        end
        checks++;
        if ({r_seq_err, l_seq_err} !== 2'b11) begin
            errors++; $display("FAIL seq_sticky: got %b expected 11", {r_seq_err, l_seq_err});
        end
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        checks++;
        if ({r_seq_err, l_seq_err} !== 2'b00) begin
            errors++; $display("FAIL seq_clear: got %b expected 00", {r_seq_err, l_seq_err});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r0, r1, l0, l1;
        logic ok;
        logic [68:0] got;
        logic [68:0] exp_v;
        setw(32'h0001_0000, 32'hFFFF_0000, 32'h0, 32'h0);
        out_rdy = 1'b0;
        for (int i = 0; i < IN_DIM; i++) send(i, 32'((i + 1) << 15));
        exp_v = {1'b1, 1'b1, 2'd0, 32'h0005_0000, 32'h0005_0000, 1'b0};
        in_valid = 1'b1; in_idx = '0; in_data = 32'h0001_0000;
        for (int c = 0; c < 5; c++) begin
            got = {r_out_valid, l_out_valid, r_out_idx, r_out_data, l_out_data, r_in_rdy | l_in_rdy};
            checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL stall_cycle%0d: got %h expected %h", c, got, exp_v);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        collect(r0, r1, l0, l1, ok);
        checks++;
        if ({ok, r0, l1} !== {1'b1, 32'h0005_0000, 32'hFFFB_0000}) begin
            errors++; $display("FAIL stall_release: got %b %h %h expected 1 00050000 fffb0000", ok, r0, l1);
        end
        for (int i = 0; i < IN_DIM; i++) send(i, 32'h0001_0000);
        collect(r0, r1, l0, l1, ok);
        checks++;
        if ({ok, r0, l1} !== {1'b1, 32'h0004_0000, 32'hFFFC_0000}) begin
            errors++; $display("FAIL next_vector: got %b %h %h expected 1 00040000 fffc0000", ok, r0, l1);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r0, r1, l0, l1;
        logic ok;
        logic [11:0] got;
        send(0, 32'h0001_0000);
        send(1, 32'h0002_0000);
        send(3, 32'h0004_0000);
        rst_n = 1'b0;
        #2;
        got = {r_in_rdy, l_in_rdy, r_out_valid, l_out_valid, r_out_last, l_out_last,
               r_seq_err, l_seq_err, r_out_idx, l_out_idx};
        checks++;
        if ({got, r_out_data, l_out_data} !== {12'b110000000000, 64'h0}) begin
            errors++; $display("FAIL midreset_vals: got %b %h %h expected 110000000000 0 0",
                               got, r_out_data, l_out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < IN_DIM; i++) send(i, 32'h0002_0000);
        collect(r0, r1, l0, l1, ok);
        checks++;
        if ({ok, r0, r1, l0, l1} !== {1'b1, 32'h0008_0000, 32'h0, 32'h0008_0000, 32'hFFF8_0000}) begin
            errors++; $display("FAIL midreset_fresh: got %b %h %h %h %h expected 1 00080000 0 00080000 fff80000",
                               ok, r0, r1, l0, l1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        load_weights = 1'b0; load_bias = 1'b0; wt_valid = 1'b0;
        wt_row = '0; wt_col = '0; wt_data = '0;
        in_valid = 1'b0; in_idx = '0; in_data = '0;
        out_rdy = 1'b1; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_identity();
        test_bias();
        test_saturation();
        test_seq_err();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
